// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: picks one exception by fixed priority, pulses its
// code to cp0_reg, and sequences the pipeline flush and the PC redirect.
module except_ctrl #(
   parameter int          FLUSH_CYCLES   = 2,
   parameter logic [31:0] EXC_VECTOR_OFF = 32'h0000_0180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic [31:0] inst_addr_i,
   input  logic        is_in_delayslot_i,
   input  logic [8:0]  exc_flags_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic [31:0] cp0_ebase_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_addr_o,
   output logic        is_in_delayslot_o,
   output logic [31:0] badvaddr_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        busy_o
);

   typedef enum logic [0:0] {IDLE, FLUSH} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] eff_status, eff_cause, eff_epc;
   logic [31:0] code, vec_pc;
   logic        irq, det;

   // WB-stage CP0 writes are not yet visible in cp0_reg; forward them here.
   always_comb begin
      eff_status = cp0_status_i;
      eff_epc    = cp0_epc_i;
      eff_cause  = cp0_cause_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) eff_status = wb_cp0_data_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) eff_epc = wb_cp0_data_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) eff_cause[9:8] = wb_cp0_data_i[9:8];
   end

   assign irq = ((eff_cause & eff_status & 32'h0000_FF00) != 32'd0) &&
                eff_status[0] && !eff_status[1];

   always_comb begin
      code = 32'h0;
      if      (irq)             code = 32'h01;
      else if (exc_flags_i[6])  code = 32'h10;
      else if (exc_flags_i[1])  code = 32'h0a;
      else if (exc_flags_i[0])  code = 32'h08;
      else if (exc_flags_i[5])  code = 32'h0f;
      else if (exc_flags_i[2])  code = 32'h0d;
      else if (exc_flags_i[3])  code = 32'h0c;
      else if (exc_flags_i[7])  code = 32'h11;
      else if (exc_flags_i[8])  code = 32'h12;
      else if (exc_flags_i[4])  code = 32'h0e;
   end

   assign det    = mem_valid_i && (code != 32'h0);
   assign vec_pc = (cp0_ebase_i & 32'hFFFF_F000) + EXC_VECTOR_OFF;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= IDLE;
         cnt                 <= 4'd0;
         excepttype_o        <= 32'h0;
         current_inst_addr_o <= 32'h0;
         is_in_delayslot_o   <= 1'b0;
         badvaddr_o          <= 32'h0;
         flush_o             <= 1'b0;
         new_pc_o            <= 32'h0;
         busy_o              <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               current_inst_addr_o <= inst_addr_i;
               is_in_delayslot_o   <= is_in_delayslot_i;
               if (det) begin
                  excepttype_o <= code;
                  flush_o      <= 1'b1;
                  busy_o       <= 1'b1;
                  cnt          <= 4'(FLUSH_CYCLES - 1);
                  state        <= FLUSH;
                  new_pc_o     <= (code == 32'h0e) ? eff_epc : vec_pc;
                  if (code == 32'h10)
                     badvaddr_o <= inst_addr_i;
                  else if (code == 32'h11 || code == 32'h12)
                     badvaddr_o <= mem_addr_i;
               end else begin
                  excepttype_o <= 32'h0;
                  flush_o      <= 1'b0;
               end
            end
            FLUSH: begin
               // Everything in the pipe is being discarded, so inputs are ignored.
               excepttype_o <= 32'h0;
               if (cnt == 4'd0) begin
                  flush_o <= 1'b0;
                  busy_o  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed vector bench for except_ctrl: table of single-exception cases plus
// hand sequences for flush-window masking and mid-flush reset.
module tb_except_ctrl;
   localparam int FC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid_i;
   logic [31:0] inst_addr_i;
   logic        is_in_delayslot_i;
   logic [8:0]  exc_flags_i;
   logic [31:0] mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i;
   logic [31:0] excepttype_o, current_inst_addr_o, badvaddr_o, new_pc_o;
   logic        is_in_delayslot_o, flush_o, busy_o;

   int checks = 0;
   int errors = 0;

   except_ctrl #(.FLUSH_CYCLES(FC), .EXC_VECTOR_OFF(32'h180)) dut (
      .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .inst_addr_i(inst_addr_i),
      .is_in_delayslot_i(is_in_delayslot_i), .exc_flags_i(exc_flags_i),
      .mem_addr_i(mem_addr_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
      .cp0_epc_i(cp0_epc_i), .cp0_ebase_i(cp0_ebase_i), .wb_cp0_we_i(wb_cp0_we_i),
      .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
      .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
      .is_in_delayslot_o(is_in_delayslot_o), .badvaddr_o(badvaddr_o),
      .flush_o(flush_o), .new_pc_o(new_pc_o), .busy_o(busy_o));

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic        ds;
      logic [8:0]  flags;
      logic [31:0] maddr, status, cause, epc, ebase;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] exp_code;
      logic [31:0] exp_pc;
      logic [31:0] exp_bad;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_valid_i = 1'b0; inst_addr_i = 32'h0; is_in_delayslot_i = 1'b0;
      exc_flags_i = 9'h0; mem_addr_i = 32'h0; cp0_status_i = 32'h0;
      cp0_cause_i = 32'h0; cp0_epc_i = 32'h0; cp0_ebase_i = 32'h8000_0000;
      wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
   endtask

   task automatic apply(input vec_t v);
      mem_valid_i = v.valid; inst_addr_i = v.pc; is_in_delayslot_i = v.ds;
      exc_flags_i = v.flags; mem_addr_i = v.maddr; cp0_status_i = v.status;
      cp0_cause_i = v.cause; cp0_epc_i = v.epc; cp0_ebase_i = v.ebase;
      wb_cp0_we_i = v.we; wb_cp0_waddr_i = v.waddr; wb_cp0_data_i = v.wdata;
   endtask

   function automatic vec_t mk(input logic valid, input logic [31:0] pc, input logic ds,
                               input logic [8:0] flags, input logic [31:0] maddr,
                               input logic [31:0] status, input logic [31:0] cause,
                               input logic [31:0] epc, input logic [31:0] ebase,
                               input logic we, input logic [4:0] waddr,
                               input logic [31:0] wdata, input logic [31:0] exp_code,
                               input logic [31:0] exp_pc, input logic [31:0] exp_bad);
      vec_t v;
      v.valid = valid; v.pc = pc; v.ds = ds; v.flags = flags; v.maddr = maddr;
      v.status = status; v.cause = cause; v.epc = epc; v.ebase = ebase; v.we = we;
      v.waddr = waddr; v.wdata = wdata; v.exp_code = exp_code; v.exp_pc = exp_pc;
      v.exp_bad = exp_bad;
      return v;
   endfunction

   initial begin
      // exp_pc of 0 on no-exception rows is unused; exp_bad is the running badvaddr.
      vecs[0]  = mk(1, 32'hBFC00100, 0, 9'h000, 0, 32'h0000FF01, 32'h0400, 0, 32'h80000000, 0, 0, 0,
                    32'h01, 32'h80000180, 32'h0);
      vecs[1]  = mk(1, 32'hBFC00104, 1, 9'h080, 32'h3, 0, 0, 0, 32'h80000000, 0, 0, 0,
                    32'h11, 32'h80000180, 32'h3);
      vecs[2]  = mk(1, 32'hBFC00108, 0, 9'h010, 0, 0, 0, 32'h1000, 32'h80000000, 1, 14, 32'h2000,
                    32'h0e, 32'h00002000, 32'h3);
      vecs[3]  = mk(1, 32'hBFC0010C, 0, 9'h00A, 0, 32'h0000FF01, 32'h0400, 0, 32'h80000000, 0, 0, 0,
                    32'h01, 32'h80000180, 32'h3);
      vecs[4]  = mk(1, 32'hBFC00110, 0, 9'h00A, 0, 32'h0000FF00, 32'h0400, 0, 32'h80000000, 0, 0, 0,
                    32'h0a, 32'h80000180, 32'h3);
      vecs[5]  = mk(1, 32'h00400002, 0, 9'h040, 32'h55, 0, 0, 0, 32'h80000000, 0, 0, 0,
                    32'h10, 32'h80000180, 32'h00400002);
      vecs[6]  = mk(1, 32'h00400010, 0, 9'h104, 32'h77, 0, 0, 0, 32'h80000000, 0, 0, 0,
                    32'h0d, 32'h80000180, 32'h00400002);
      vecs[7]  = mk(1, 32'h00400014, 1, 9'h021, 0, 0, 0, 0, 32'h80000000, 0, 0, 0,
                    32'h08, 32'h80000180, 32'h00400002);
      vecs[8]  = mk(1, 32'h00400018, 0, 9'h000, 0, 0, 32'h0400, 0, 32'h80000000, 1, 12, 32'h0000FF01,
                    32'h01, 32'h80000180, 32'h00400002);
      vecs[9]  = mk(1, 32'h0040001C, 0, 9'h000, 0, 32'h0000FF01, 0, 0, 32'h80000000, 1, 13, 32'h300,
                    32'h01, 32'h80000180, 32'h00400002);
      vecs[10] = mk(1, 32'h00400020, 0, 9'h008, 0, 32'h0000FF03, 32'h0400, 0, 32'h80000000, 0, 0, 0,
                    32'h0c, 32'h80000180, 32'h00400002);
      vecs[11] = mk(1, 32'h00400024, 0, 9'h100, 32'hDEAD0001, 0, 0, 0, 32'h9FC01234, 0, 0, 0,
                    32'h12, 32'h9FC01180, 32'hDEAD0001);
      vecs[12] = mk(1, 32'h00400028, 1, 9'h000, 0, 0, 32'h0400, 0, 32'h80000000, 0, 0, 0,
                    32'h00, 32'h0, 32'hDEAD0001);
      vecs[13] = mk(0, 32'h0040002C, 0, 9'h041, 32'h99, 32'h0000FF01, 32'h0400, 0, 32'h80000000, 0, 0, 0,
                    32'h00, 32'h0, 32'hDEAD0001);

      idle_inputs();
      rst = 1'b0;
      #12;
      chk("reset excepttype", excepttype_o, 32'h0);
      chk("reset flush", {31'h0, flush_o}, 32'h0);
      chk("reset new_pc", new_pc_o, 32'h0);
      chk("reset badvaddr", badvaddr_o, 32'h0);
      chk("reset busy", {31'h0, busy_o}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      step();

      for (int i = 0; i < 14; i++) begin
         apply(vecs[i]);
         step();
         chk($sformatf("v%0d code", i), excepttype_o, vecs[i].exp_code);
         chk($sformatf("v%0d cur_pc", i), current_inst_addr_o, vecs[i].pc);
         chk($sformatf("v%0d ds", i), {31'h0, is_in_delayslot_o}, {31'h0, vecs[i].ds});
         chk($sformatf("v%0d badvaddr", i), badvaddr_o, vecs[i].exp_bad);
         chk($sformatf("v%0d flush", i), {31'h0, flush_o}, {31'h0, vecs[i].exp_code != 0});
         if (vecs[i].exp_code != 0) begin
            chk($sformatf("v%0d new_pc", i), new_pc_o, vecs[i].exp_pc);
            idle_inputs();
            for (int k = 1; k < FC; k++) begin
               step();
               chk($sformatf("v%0d flush hold", i), {31'h0, flush_o}, 32'h1);
               chk($sformatf("v%0d code pulse", i), excepttype_o, 32'h0);
               chk($sformatf("v%0d new_pc hold", i), new_pc_o, vecs[i].exp_pc);
            end
            step();
            chk($sformatf("v%0d flush end", i), {31'h0, flush_o}, 32'h0);
            chk($sformatf("v%0d busy end", i), {31'h0, busy_o}, 32'h0);
         end
      end

      // Exception offered during FLUSH is ignored, then taken back in IDLE.
      idle_inputs();
      mem_valid_i = 1'b1; inst_addr_i = 32'h1000; exc_flags_i = 9'h001;
      step();
      chk("seq5 first code", excepttype_o, 32'h08);
      exc_flags_i = 9'h020; inst_addr_i = 32'h2000;
      step();
      chk("seq5 during flush", excepttype_o, 32'h0);
      chk("seq5 busy", {31'h0, busy_o}, 32'h1);
      chk("seq5 cur_pc held", current_inst_addr_o, 32'h1000);
      step();
      chk("seq5 back idle", excepttype_o, 32'h0);
      chk("seq5 flush low", {31'h0, flush_o}, 32'h0);
      step();
      chk("seq5 retaken code", excepttype_o, 32'h0f);
      chk("seq5 retaken pc", current_inst_addr_o, 32'h2000);
      idle_inputs();
      repeat (FC) step();

      // Interrupt held through FLUSH is taken on the first valid IDLE cycle.
      mem_valid_i = 1'b1; exc_flags_i = 9'h001; inst_addr_i = 32'h3000;
      step();
      chk("irq-hold first", excepttype_o, 32'h08);
      exc_flags_i = 9'h0; cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h0800;
      repeat (FC) step();
      chk("irq-hold idle gap", excepttype_o, 32'h0);
      step();
      chk("irq-hold taken", excepttype_o, 32'h01);
      idle_inputs();
      repeat (FC) step();

      // Reset in the middle of a flush.
      mem_valid_i = 1'b1; exc_flags_i = 9'h002; inst_addr_i = 32'h4000;
      step();
      chk("rst seq code", excepttype_o, 32'h0a);
      idle_inputs();
      #2 rst = 1'b0;
      #1;
      chk("rst mid flush", {31'h0, flush_o}, 32'h0);
      chk("rst mid code", excepttype_o, 32'h0);
      chk("rst mid new_pc", new_pc_o, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         step();
         chk("post rst flush", {31'h0, flush_o}, 32'h0);
         chk("post rst code", excepttype_o, 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
